// File: rtl/ps2_pkg.sv
// Shared scan-code constants, parser state encoding and key event payload
// for the PS/2 key event decoder.
package ps2_pkg;

  localparam logic [7:0] SC_EXT   = 8'hE0;
  localparam logic [7:0] SC_BRK   = 8'hF0;
  localparam logic [7:0] SC_PAUSE = 8'hE1;

  // Pause sends E1 followed by seven more bytes that carry no key state.
  localparam int unsigned PAUSE_SKIP = 7;
  localparam int unsigned SKIP_W     = 3;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_EXT     = 2'd1,
    ST_BRK     = 2'd2,
    ST_EXT_BRK = 2'd3
  } parse_state_t;

  typedef struct packed {
    logic [7:0] code;
    logic       ext;
    logic       brk;
  } key_event_t;

endpackage

// File: rtl/ps2_event_fifo.sv
// First-word-fall-through FIFO of key events. The head entry is kept in its
// own register so every output is a flop.
module ps2_event_fifo
  import ps2_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       push,
  input  key_event_t push_data,
  input  logic       pop,
  output key_event_t head,
  output logic       valid,
  output logic       full
);

  localparam int unsigned AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned CW = AW + 1;

  key_event_t    mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW-1:0] rd_nxt;
  logic [CW-1:0] count;
  logic [CW-1:0] cnt_nxt;
  logic          push_ok;
  logic          pop_ok;

  // Qualified handshakes and next occupancy / read pointer.
  always_comb begin
    push_ok = push & ~full;
    pop_ok  = pop & valid;
    cnt_nxt = count + CW'(push_ok) - CW'(pop_ok);
    rd_nxt  = pop_ok ? rd_ptr + AW'(1) : rd_ptr;
  end

  // Storage array; contents need no reset because the head register masks it.
  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem[wr_ptr] <= push_data;
    end
  end

  // Pointers, occupancy flags and the fall-through head register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      valid  <= 1'b0;
      full   <= 1'b0;
      head   <= '0;
    end else begin
      if (push_ok) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      rd_ptr <= rd_nxt;
      count  <= cnt_nxt;
      valid  <= (cnt_nxt != '0);
      full   <= (cnt_nxt == CW'(FIFO_DEPTH));
      if (push_ok && ((count == '0) || (pop_ok && (count == CW'(1))))) begin
        head <= push_data;
      end else if (pop_ok) begin
        head <= mem[rd_nxt];
      end
    end
  end

endmodule

// File: rtl/ps2_key_event_fsm.sv
// PS/2 scan-code decoder: pops bytes from ps2_keyboard, strips E0/F0/E1
// prefixes, tracks held keys, counts presses and queues key events.
// Build option: PS2_TYPEMATIC_FILTER_EN drops typematic repeats of held keys
// entirely; without it repeats still emit a press event and update last_*.
module ps2_key_event_fsm
  import ps2_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH = 8,
  parameter int unsigned HELD_SLOTS = 4,
  parameter int unsigned COUNT_W    = 8
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic [7:0]                        kb_data,
  input  logic                              kb_ready,
  input  logic                              kb_overflow,
  output logic                              kb_nextdata_n,
  output logic                              ev_valid,
  input  logic                              ev_ready,
  output logic [7:0]                        ev_code,
  output logic                              ev_ext,
  output logic                              ev_break,
  output logic [COUNT_W-1:0]                press_count,
  output logic [7:0]                        last_code,
  output logic                              last_ext,
  output logic [$clog2(HELD_SLOTS+1)-1:0]   held_count,
  input  logic                              err_clr,
  output logic                              proto_err,
  output logic                              held_ovf,
  output logic                              rx_ovf
);

  localparam int unsigned HC_W = $clog2(HELD_SLOTS + 1);

  parse_state_t          state;
  parse_state_t          state_nxt;
  logic [SKIP_W-1:0]     skip_cnt;
  logic [SKIP_W-1:0]     skip_nxt;
  logic                  consume_c;
  logic                  fifo_full;
  logic                  press_c;
  logic                  release_c;
  logic                  key_ext_c;
  logic                  proto_set_c;
  logic [8:0]            key_c;
  logic [HELD_SLOTS-1:0] held_vld;
  logic [8:0]            held_key [HELD_SLOTS];
  logic [HELD_SLOTS-1:0] match_oh;
  logic [HELD_SLOTS-1:0] free_oh;
  logic [HELD_SLOTS-1:0] ins_oh;
  logic [HELD_SLOTS-1:0] rel_oh;
  logic                  hit_c;
  logic                  new_press_c;
  logic                  push_c;
  logic                  last_upd_c;
  logic                  held_ovf_set_c;
  key_event_t            push_ev_c;
  key_event_t            head;

  // A byte is taken only while the pop strobe is idle and the queue has room.
  assign consume_c = kb_ready & kb_nextdata_n & ~fifo_full;

  // Parser state and pause-skip counter registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= ST_IDLE;
      skip_cnt <= '0;
    end else begin
      state    <= state_nxt;
      skip_cnt <= skip_nxt;
    end
  end

  // Prefix decoding: classify each consumed byte as prefix, press or release.
  always_comb begin
    state_nxt   = state;
    skip_nxt    = skip_cnt;
    press_c     = 1'b0;
    release_c   = 1'b0;
    key_ext_c   = 1'b0;
    proto_set_c = 1'b0;
    if (consume_c) begin
      if (skip_cnt != '0) begin
        skip_nxt = skip_cnt - SKIP_W'(1);
      end else begin
        unique case (state)
          ST_IDLE: begin
            if (kb_data == SC_PAUSE) begin
              skip_nxt = SKIP_W'(PAUSE_SKIP);
            end else if (kb_data == SC_EXT) begin
              state_nxt = ST_EXT;
            end else if (kb_data == SC_BRK) begin
              state_nxt = ST_BRK;
            end else begin
              press_c = 1'b1;
            end
          end
          ST_EXT: begin
            if (kb_data == SC_BRK) begin
              state_nxt = ST_EXT_BRK;
            end else if (kb_data == SC_EXT) begin
              proto_set_c = 1'b1;
            end else begin
              press_c   = 1'b1;
              key_ext_c = 1'b1;
              state_nxt = ST_IDLE;
            end
          end
          ST_BRK: begin
            if ((kb_data == SC_EXT) || (kb_data == SC_BRK)) begin
              proto_set_c = 1'b1;
            end else begin
              release_c = 1'b1;
              state_nxt = ST_IDLE;
            end
          end
          ST_EXT_BRK: begin
            if ((kb_data == SC_EXT) || (kb_data == SC_BRK)) begin
              proto_set_c = 1'b1;
            end else begin
              release_c = 1'b1;
              key_ext_c = 1'b1;
              state_nxt = ST_IDLE;
            end
          end
          default: state_nxt = ST_IDLE;
        endcase
      end
    end
  end

  // Held-table lookup: matching slot and lowest free slot, both one-hot.
  always_comb begin
    logic found;
    found    = 1'b0;
    key_c    = {key_ext_c, kb_data};
    match_oh = '0;
    free_oh  = '0;
    for (int i = 0; i < int'(HELD_SLOTS); i++) begin
      match_oh[i] = held_vld[i] && (held_key[i] == key_c);
      if (!held_vld[i] && !found) begin
        free_oh[i] = 1'b1;
        found      = 1'b1;
      end
    end
  end

  // Event generation and table update decisions for the decoded key.
  always_comb begin
    hit_c          = |match_oh;
    new_press_c    = press_c & ~hit_c;
    ins_oh         = new_press_c ? free_oh : '0;
    rel_oh         = release_c ? match_oh : '0;
    held_ovf_set_c = new_press_c & ~(|free_oh);
`ifdef PS2_TYPEMATIC_FILTER_EN
    push_c         = new_press_c | release_c;
    last_upd_c     = new_press_c;
`else
    push_c         = press_c | release_c;
    last_upd_c     = press_c;
`endif
    push_ev_c.code = kb_data;
    push_ev_c.ext  = key_ext_c;
    push_ev_c.brk  = release_c;
  end

  // Receiver pop strobe: low for exactly the cycle after a consume.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      kb_nextdata_n <= 1'b1;
    end else begin
      kb_nextdata_n <= ~consume_c;
    end
  end

  // Held-key table and its occupancy count.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      held_vld   <= '0;
      held_count <= '0;
      for (int i = 0; i < int'(HELD_SLOTS); i++) begin
        held_key[i] <= '0;
      end
    end else begin
      for (int i = 0; i < int'(HELD_SLOTS); i++) begin
        if (ins_oh[i]) begin
          held_vld[i] <= 1'b1;
          held_key[i] <= key_c;
        end else if (rel_oh[i]) begin
          held_vld[i] <= 1'b0;
        end
      end
      if (|ins_oh) begin
        held_count <= held_count + HC_W'(1);
      end else if (|rel_oh) begin
        held_count <= held_count - HC_W'(1);
      end
    end
  end

  // Press counter and most-recent-press registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      press_count <= '0;
      last_code   <= '0;
      last_ext    <= 1'b0;
    end else begin
      if (new_press_c) begin
        press_count <= press_count + COUNT_W'(1);
      end
      if (last_upd_c) begin
        last_code <= kb_data;
        last_ext  <= key_ext_c;
      end
    end
  end

  // Sticky error flags; a set in the same cycle as err_clr wins.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      proto_err <= 1'b0;
      held_ovf  <= 1'b0;
      rx_ovf    <= 1'b0;
    end else begin
      proto_err <= proto_set_c | (proto_err & ~err_clr);
      held_ovf  <= held_ovf_set_c | (held_ovf & ~err_clr);
      rx_ovf    <= kb_overflow | (rx_ovf & ~err_clr);
    end
  end

  ps2_event_fifo #(
    .FIFO_DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (push_c),
    .push_data (push_ev_c),
    .pop       (ev_ready),
    .head      (head),
    .valid     (ev_valid),
    .full      (fifo_full)
  );

  assign ev_code  = head.code;
  assign ev_ext   = head.ext;
  assign ev_break = head.brk;

endmodule

// File: tb/tb_ps2_key_event_fsm.sv
// Self-checking bench for ps2_key_event_fsm: a queue-based receiver model
// feeds bytes, and a scan-code reference model predicts events and status.
module tb_ps2_key_event_fsm;

  localparam int unsigned FIFO_DEPTH = 8;
  localparam int unsigned HELD_SLOTS = 4;
  localparam int unsigned COUNT_W    = 8;
  localparam int unsigned HC_W       = $clog2(HELD_SLOTS + 1);

  logic               clk;
  logic               rst_n;
  logic [7:0]         kb_data;
  logic               kb_ready;
  logic               kb_overflow;
  logic               kb_nextdata_n;
  logic               ev_valid;
  logic               ev_ready;
  logic [7:0]         ev_code;
  logic               ev_ext;
  logic               ev_break;
  logic [COUNT_W-1:0] press_count;
  logic [7:0]         last_code;
  logic               last_ext;
  logic [HC_W-1:0]    held_count;
  logic               err_clr;
  logic               proto_err;
  logic               held_ovf;
  logic               rx_ovf;

  ps2_key_event_fsm #(
    .FIFO_DEPTH (FIFO_DEPTH),
    .HELD_SLOTS (HELD_SLOTS),
    .COUNT_W    (COUNT_W)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .kb_data       (kb_data),
    .kb_ready      (kb_ready),
    .kb_overflow   (kb_overflow),
    .kb_nextdata_n (kb_nextdata_n),
    .ev_valid      (ev_valid),
    .ev_ready      (ev_ready),
    .ev_code       (ev_code),
    .ev_ext        (ev_ext),
    .ev_break      (ev_break),
    .press_count   (press_count),
    .last_code     (last_code),
    .last_ext      (last_ext),
    .held_count    (held_count),
    .err_clr       (err_clr),
    .proto_err     (proto_err),
    .held_ovf      (held_ovf),
    .rx_ovf        (rx_ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  logic [7:0] rx_q [$];
  logic [9:0] exp_q [$];
  logic [9:0] got_q [$];
  int         rdy_mode;

  // Reference model state: prefix flags, skip budget and the set of held keys.
  bit         m_ext;
  bit         m_brk;
  int         m_skip;
  logic [8:0] m_held [$];
  int         m_count;
  logic [7:0] m_last_code;
  bit         m_last_ext;
  bit         m_proto;
  bit         m_hovf;

  function automatic void model_reset();
    m_ext = 0; m_brk = 0; m_skip = 0; m_held.delete(); m_count = 0;
    m_last_code = 8'h00; m_last_ext = 0; m_proto = 0; m_hovf = 0;
    rx_q.delete(); exp_q.delete(); got_q.delete();
  endfunction

  function automatic void model_byte(logic [7:0] b);
    logic [8:0] key;
    int idx;
    if (m_skip > 0) begin
      m_skip--;
    end else if (!m_ext && !m_brk && b == 8'hE1) begin
      m_skip = 7;
    end else if (b == 8'hE0) begin
      if (m_ext || m_brk) m_proto = 1; else m_ext = 1;
    end else if (b == 8'hF0) begin
      if (m_brk) m_proto = 1; else m_brk = 1;
    end else begin
      key = {m_ext, b};
      idx = -1;
      foreach (m_held[i]) if (m_held[i] == key) idx = i;
      if (m_brk) begin
        if (idx >= 0) m_held.delete(idx);
        exp_q.push_back({b, m_ext, 1'b1});
      end else if (idx >= 0) begin
`ifndef PS2_TYPEMATIC_FILTER_EN
        exp_q.push_back({b, m_ext, 1'b0});
        m_last_code = b;
        m_last_ext  = m_ext;
`endif
      end else begin
        exp_q.push_back({b, m_ext, 1'b0});
        m_count     = (m_count + 1) % (1 << COUNT_W);
        m_last_code = b;
        m_last_ext  = m_ext;
        if (m_held.size() < int'(HELD_SLOTS)) m_held.push_back(key);
        else m_hovf = 1;
      end
      m_ext = 0;
      m_brk = 0;
    end
  endfunction

  // One clock: present receiver head, record popped events, track consumes.
  task automatic cycle();
    @(negedge clk);
    kb_ready = (rx_q.size() > 0);
    kb_data  = kb_ready ? rx_q[0] : 8'h00;
    case (rdy_mode)
      0:       ev_ready = 1'b0;
      1:       ev_ready = 1'b1;
      default: ev_ready = ($urandom_range(0, 2) != 0);
    endcase
    #1;
    if (ev_valid && ev_ready) got_q.push_back({ev_code, ev_ext, ev_break});
    @(posedge clk);
    #1;
    if (!kb_nextdata_n && rx_q.size() > 0) model_byte(rx_q.pop_front());
  endtask

  // Run until all bytes are consumed (and events drained when popping).
  task automatic run(input int max_cycles, output bit timed_out);
    int n;
    n = 0;
    timed_out = 0;
    while (rx_q.size() > 0 || (rdy_mode != 0 && ev_valid)) begin
      if (n >= max_cycles) begin
        timed_out = 1;
        break;
      end
      cycle();
      n++;
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    kb_ready = 1'b0; kb_data = 8'h00; kb_overflow = 1'b0;
    ev_ready = 1'b0; err_clr = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    do_reset();
    #1;
    tests++;
    if ({kb_nextdata_n, ev_valid, ev_code, ev_ext, ev_break, press_count, last_code,
         last_ext, held_count, proto_err, held_ovf, rx_ovf} !==
        {1'b1, 1'b0, 8'h00, 1'b0, 1'b0, COUNT_W'(0), 8'h00, 1'b0, HC_W'(0), 3'b000}) begin
      fails++;
      $display("FAIL reset_outputs got nd=%b v=%b code=%h cnt=%0d held=%0d flags=%b%b%b",
               kb_nextdata_n, ev_valid, ev_code, press_count, held_count, proto_err, held_ovf, rx_ovf);
    end
  endtask

  task automatic test_basic();
    bit to;
    do_reset();
    rdy_mode = 1;
    rx_q.push_back(8'h1C);
    run(200, to);
    tests++;
    if (to || held_count !== HC_W'(1)) begin
      fails++; $display("FAIL basic_held_after_press got %0d exp 1 (timeout=%0b)", held_count, to);
    end
    rx_q.push_back(8'hF0); rx_q.push_back(8'h1C);
    run(200, to);
    tests++;
    if (to || held_count !== HC_W'(0)) begin
      fails++; $display("FAIL basic_held_after_release got %0d exp 0 (timeout=%0b)", held_count, to);
    end
    tests++;
    if ({press_count, last_code} !== {COUNT_W'(1), 8'h1C}) begin
      fails++; $display("FAIL basic_count_last got %0d/%h exp 1/1c", press_count, last_code);
    end
    tests++;
    if (got_q.size() != 2 || got_q[0] !== {8'h1C, 2'b00} || got_q[1] !== {8'h1C, 2'b01}) begin
      fails++; $display("FAIL basic_events got n=%0d first=%h exp n=2 070,071", got_q.size(),
                        (got_q.size() > 0) ? got_q[0] : 10'h3FF);
    end
  endtask

  task automatic test_ext();
    bit to;
    logic [7:0] seq [5] = '{8'hE0, 8'h75, 8'hE0, 8'hF0, 8'h75};
    do_reset();
    rdy_mode = 1;
    foreach (seq[i]) rx_q.push_back(seq[i]);
    run(200, to);
    tests++;
    if (to || got_q.size() != 2 || got_q[0] !== {8'h75, 2'b10} || got_q[1] !== {8'h75, 2'b11}) begin
      fails++; $display("FAIL ext_events got n=%0d timeout=%0b exp n=2", got_q.size(), to);
    end
    tests++;
    if ({last_code, last_ext, proto_err, held_count} !== {8'h75, 1'b1, 1'b0, HC_W'(0)}) begin
      fails++; $display("FAIL ext_status got last=%h ext=%b proto=%b held=%0d exp 75/1/0/0",
                        last_code, last_ext, proto_err, held_count);
    end
  endtask

  task automatic test_typematic();
    bit to;
    int exp_n;
    logic [7:0] seq [5] = '{8'h1C, 8'h1C, 8'h1C, 8'hF0, 8'h1C};
`ifdef PS2_TYPEMATIC_FILTER_EN
    exp_n = 2;
`else
    exp_n = 4;
`endif
    do_reset();
    rdy_mode = 1;
    foreach (seq[i]) rx_q.push_back(seq[i]);
    run(200, to);
    tests++;
    if (to || got_q.size() != exp_n) begin
      fails++; $display("FAIL typematic_event_count got %0d exp %0d", got_q.size(), exp_n);
    end
    tests++;
    if (press_count !== COUNT_W'(1) || held_count !== HC_W'(0)) begin
      fails++; $display("FAIL typematic_counts got cnt=%0d held=%0d exp 1/0", press_count, held_count);
    end
    foreach (exp_q[i]) if (i < got_q.size()) begin
      tests++;
      if (got_q[i] !== exp_q[i]) begin
        fails++; $display("FAIL typematic_ev%0d got %h exp %h", i, got_q[i], exp_q[i]);
      end
    end
  endtask

  task automatic test_held_ovf();
    bit to;
    logic [7:0] seq [5] = '{8'h15, 8'h1D, 8'h24, 8'h2D, 8'h2C};
    do_reset();
    rdy_mode = 1;
    foreach (seq[i]) rx_q.push_back(seq[i]);
    run(200, to);
    tests++;
    if (to || got_q.size() != 5 || held_count !== HC_W'(4) || held_ovf !== 1'b1 || press_count !== COUNT_W'(5)) begin
      fails++; $display("FAIL held_ovf_set got n=%0d held=%0d ovf=%b cnt=%0d exp 5/4/1/5",
                        got_q.size(), held_count, held_ovf, press_count);
    end
    @(negedge clk); err_clr = 1'b1;
    @(posedge clk); #1; err_clr = 1'b0;
    tests++;
    if (held_ovf !== 1'b0 || held_count !== HC_W'(4)) begin
      fails++; $display("FAIL held_ovf_clear got ovf=%b held=%0d exp 0/4", held_ovf, held_count);
    end
  endtask

  task automatic test_stall();
    bit to;
    bit stuck;
    logic [7:0] seq [9] = '{8'h15, 8'h1D, 8'h24, 8'h2D, 8'h2C, 8'h35, 8'h3C, 8'h43, 8'h44};
    do_reset();
    rdy_mode = 0;
    foreach (seq[i]) rx_q.push_back(seq[i]);
    repeat (40) cycle();
    tests++;
    if (rx_q.size() != 1 || ev_valid !== 1'b1 || exp_q.size() != 8) begin
      fails++; $display("FAIL stall_fill got left=%0d valid=%b queued=%0d exp 1/1/8",
                        rx_q.size(), ev_valid, exp_q.size());
    end
    stuck = 1;
    repeat (6) begin
      cycle();
      if (!kb_nextdata_n) stuck = 0;
    end
    tests++;
    if (!stuck) begin
      fails++; $display("FAIL stall_hold got pop strobe while full exp none");
    end
    rdy_mode = 1;
    run(400, to);
    tests++;
    if (to || got_q.size() != 9) begin
      fails++; $display("FAIL stall_drain got n=%0d timeout=%0b exp 9", got_q.size(), to);
    end
    foreach (got_q[i]) begin
      tests++;
      if (got_q[i] !== {seq[i], 2'b00}) begin
        fails++; $display("FAIL stall_ev%0d got %h exp %h", i, got_q[i], {seq[i], 2'b00});
      end
    end
  endtask

  task automatic test_pause_proto();
    bit to;
    logic [7:0] seq [9] = '{8'hE1, 8'h14, 8'h77, 8'hE1, 8'hF0, 8'h14, 8'hF0, 8'h77, 8'h1C};
    do_reset();
    rdy_mode = 1;
    foreach (seq[i]) rx_q.push_back(seq[i]);
    run(200, to);
    tests++;
    if (to || got_q.size() != 1 || got_q[0] !== {8'h1C, 2'b00} || proto_err !== 1'b0) begin
      fails++; $display("FAIL pause_skip got n=%0d proto=%b exp 1 event 1c, proto 0", got_q.size(), proto_err);
    end
    rx_q.push_back(8'hF0); rx_q.push_back(8'hF0); rx_q.push_back(8'h1C);
    run(200, to);
    tests++;
    if (to || proto_err !== 1'b1 || got_q.size() != 2 || got_q[1] !== {8'h1C, 2'b01} || held_count !== HC_W'(0)) begin
      fails++; $display("FAIL proto_brk_brk got proto=%b n=%0d held=%0d exp 1/2/0", proto_err, got_q.size(), held_count);
    end
  endtask

  task automatic test_rx_ovf();
    do_reset();
    @(negedge clk); kb_overflow = 1'b1;
    @(posedge clk); #1;
    tests++;
    if (rx_ovf !== 1'b1) begin
      fails++; $display("FAIL rx_ovf_set got %b exp 1", rx_ovf);
    end
    @(negedge clk); err_clr = 1'b1;
    @(posedge clk); #1;
    tests++;
    if (rx_ovf !== 1'b1) begin
      fails++; $display("FAIL rx_ovf_set_wins got %b exp 1", rx_ovf);
    end
    @(negedge clk); kb_overflow = 1'b0;
    @(posedge clk); #1;
    err_clr = 1'b0;
    tests++;
    if (rx_ovf !== 1'b0) begin
      fails++; $display("FAIL rx_ovf_clear got %b exp 0", rx_ovf);
    end
  endtask

  task automatic test_reset_mid();
    bit to;
    do_reset();
    rdy_mode = 1;
    rx_q.push_back(8'h1C);
    rx_q.push_back(8'hE0);
    run(200, to);
    do_reset();
    #1;
    tests++;
    if ({ev_valid, press_count, held_count, last_code} !== {1'b0, COUNT_W'(0), HC_W'(0), 8'h00}) begin
      fails++; $display("FAIL reset_mid_outputs got v=%b cnt=%0d held=%0d last=%h exp 0/0/0/00",
                        ev_valid, press_count, held_count, last_code);
    end
    rdy_mode = 1;
    rx_q.push_back(8'h1C);
    run(200, to);
    tests++;
    if (to || got_q.size() != 1 || got_q[0] !== {8'h1C, 2'b00} || last_ext !== 1'b0) begin
      fails++; $display("FAIL reset_mid_prefix got n=%0d ext=%b exp 1 plain press", got_q.size(), last_ext);
    end
  endtask

  task automatic test_random();
    bit to;
    int r;
    logic [7:0] codes [7] = '{8'h1C, 8'h1D, 8'h24, 8'h2D, 8'h2C, 8'h75, 8'h14};
    do_reset();
    rdy_mode = 2;
    for (int n = 0; n < 400; n++) begin
      r = $urandom_range(0, 99);
      if (r < 45)      rx_q.push_back(codes[$urandom_range(0, 6)]);
      else if (r < 65) rx_q.push_back(8'hF0);
      else if (r < 80) rx_q.push_back(8'hE0);
      else if (r < 84) rx_q.push_back(8'hE1);
      else             rx_q.push_back(8'($urandom_range(0, 255)));
    end
    run(20000, to);
    tests++;
    if (to || got_q.size() != exp_q.size()) begin
      fails++; $display("FAIL random_event_count got %0d exp %0d timeout=%0b", got_q.size(), exp_q.size(), to);
    end
    foreach (exp_q[i]) if (i < got_q.size()) begin
      tests++;
      if (got_q[i] !== exp_q[i]) begin
        fails++; $display("FAIL random_ev%0d got %h exp %h", i, got_q[i], exp_q[i]);
      end
    end
    tests++;
    if ({press_count, last_code, last_ext, held_count, proto_err, held_ovf} !==
        {COUNT_W'(m_count), m_last_code, m_last_ext, HC_W'(m_held.size()), m_proto, m_hovf}) begin
      fails++; $display("FAIL random_status got cnt=%0d last=%h/%b held=%0d flags=%b%b exp %0d %h/%b %0d %b%b",
                        press_count, last_code, last_ext, held_count, proto_err, held_ovf,
                        m_count, m_last_code, m_last_ext, m_held.size(), m_proto, m_hovf);
    end
  endtask

  initial begin
    rdy_mode = 0;
    rst_n = 1'b0; kb_ready = 1'b0; kb_data = 8'h00; kb_overflow = 1'b0;
    ev_ready = 1'b0; err_clr = 1'b0;
    test_reset();
    test_basic();
    test_ext();
    test_typematic();
    test_held_ovf();
    test_stall();
    test_pause_proto();
    test_rx_ovf();
    test_reset_mid();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog simulation did not finish, got timeout exp completion");
    $fatal(1, "watchdog");
  end

endmodule
